// File: rtl/ctr_reg_pkg.sv
// rtl/ctr_reg_pkg.sv - operation encoding and control priority decode for ctr_reg
package ctr_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LD   = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6
    } op_e;

    localparam bit SAT_WRAP     = 1'b0;
    localparam bit SAT_SATURATE = 1'b1;

    // Simultaneous inc and dec cancel out to a plain hold.
    function automatic op_e decode_op(
        input logic clr,
        input logic ld,
        input logic inr,
        input logic dcr,
        input logic shl,
        input logic shr
    );
        op_e op;
        if (clr)             op = OP_CLR;
        else if (ld)         op = OP_LD;
        else if (inr && dcr) op = OP_HOLD;
        else if (inr)        op = OP_INC;
        else if (dcr)        op = OP_DEC;
        else if (shl)        op = OP_SHL;
        else if (shr)        op = OP_SHR;
        else                 op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/ctr_reg_alu.sv
// rtl/ctr_reg_alu.sv - next-value, carry-out and overflow-event logic for ctr_reg
module ctr_reg_alu
    import ctr_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit SAT   = SAT_WRAP
) (
    input  logic [WIDTH-1:0] reg_q,
    input  op_e              op,
    input  logic             sin,
    output logic [WIDTH-1:0] reg_d,
    output logic             cout_d,
    output logic             ovf_event
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Extra MSB holds the carry/borrow; it never reaches the register.
    assign sum  = {1'b0, reg_q} + {{WIDTH{1'b0}}, 1'b1};
    assign diff = {1'b0, reg_q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        reg_d     = reg_q;
        cout_d    = 1'b0;
        ovf_event = 1'b0;
        case (op)
            OP_CLR: reg_d = '0;
            OP_INC: begin
                cout_d    = sum[WIDTH];
                ovf_event = sum[WIDTH];
                if (!(sum[WIDTH] && SAT == SAT_SATURATE)) reg_d = sum[WIDTH-1:0];
            end
            OP_DEC: begin
                cout_d    = diff[WIDTH];
                ovf_event = diff[WIDTH];
                if (!(diff[WIDTH] && SAT == SAT_SATURATE)) reg_d = diff[WIDTH-1:0];
            end
            OP_SHL: begin
                reg_d  = {reg_q[WIDTH-2:0], sin};
                cout_d = reg_q[WIDTH-1];
            end
            OP_SHR: begin
                reg_d  = {sin, reg_q[WIDTH-1:1]};
                cout_d = reg_q[0];
            end
            default: reg_d = reg_q;
        endcase
    end

endmodule

// File: rtl/ctr_reg.sv
// rtl/ctr_reg.sv - parametrised load/inc/dec/shift register with carry, overflow and zero flags
module ctr_reg
    import ctr_reg_pkg::*;
#(
    parameter int             WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit             SAT     = SAT_WRAP
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             regCLR,
    input  logic             regLD,
    input  logic             regINR,
    input  logic             regDCR,
    input  logic             regSHL,
    input  logic             regSHR,
    input  logic             SIN,
    input  logic [WIDTH-1:0] inReg,
    output logic [WIDTH-1:0] REG,
    output logic             COUT,
    output logic             OVF,
    output logic             Z
);

    op_e              op;
    logic [WIDTH-1:0] alu_reg;
    logic             alu_cout;
    logic             alu_ovf;

    logic [WIDTH-1:0] reg_q, reg_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    assign op = decode_op(regCLR, regLD, regINR, regDCR, regSHL, regSHR);

    ctr_reg_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .reg_q     (reg_q),
        .op        (op),
        .sin       (SIN),
        .reg_d     (alu_reg),
        .cout_d    (alu_cout),
        .ovf_event (alu_ovf)
    );

    always_comb begin
        reg_d  = (op == OP_LD) ? inReg : alu_reg;
        cout_d = alu_cout;
        ovf_d  = (op == OP_CLR) ? 1'b0 : (ovf_q | alu_ovf);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            reg_q  <= RST_VAL;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign REG  = reg_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign Z    = (reg_q == '0);

endmodule

// File: tb/tb_ctr_reg.sv
// tb/tb_ctr_reg.sv - directed self-checking bench for ctr_reg in wrap and saturate modes
module tb_ctr_reg;

    localparam int          W    = 16;
    localparam logic [15:0] RSTV = 16'h0100;

    logic         clk = 1'b0;
    logic         rstn, clr, ld, inr, dcr, shl, shr, sin;
    logic [W-1:0] in_reg;

    logic [W-1:0] reg_w, reg_s;
    logic         cout_w, cout_s, ovf_w, ovf_s, z_w, z_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctr_reg #(.WIDTH(W), .RST_VAL(RSTV), .SAT(1'b0)) u_wrap (
        .CLK(clk), .RSTn(rstn), .regCLR(clr), .regLD(ld), .regINR(inr), .regDCR(dcr),
        .regSHL(shl), .regSHR(shr), .SIN(sin), .inReg(in_reg),
        .REG(reg_w), .COUT(cout_w), .OVF(ovf_w), .Z(z_w)
    );

    ctr_reg #(.WIDTH(W), .RST_VAL(RSTV), .SAT(1'b1)) u_sat (
        .CLK(clk), .RSTn(rstn), .regCLR(clr), .regLD(ld), .regINR(inr), .regDCR(dcr),
        .regSHL(shl), .regSHR(shr), .SIN(sin), .inReg(in_reg),
        .REG(reg_s), .COUT(cout_s), .OVF(ovf_s), .Z(z_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic c, input logic l, input logic i, input logic d,
                       input logic sl, input logic sr);
        clr = c; ld = l; inr = i; dcr = d; shl = sl; shr = sr;
    endtask

    initial begin
        rstn = 1'b0; sin = 1'b0; in_reg = '0;
        ctl(0, 0, 0, 0, 0, 0);
        step();
        check("rst_reg",  reg_w, 32'h0100);
        check("rst_cout", cout_w, 0);
        check("rst_ovf",  ovf_w, 0);
        check("rst_z",    z_w, 0);
        check("rst_reg_s", reg_s, 32'h0100);

        rstn = 1'b1;
        ctl(1, 0, 0, 0, 0, 0);
        step();
        check("clr_reg", reg_w, 0);
        check("clr_z",   z_w, 1);

        // wrap-mode increment across all-ones
        ctl(0, 1, 0, 0, 0, 0); in_reg = 16'hFFFE;
        step();
        ctl(0, 0, 1, 0, 0, 0);
        step();
        check("inc1_reg", reg_w, 32'hFFFF);
        check("inc1_cout", cout_w, 0);
        step();
        check("inc2_reg_w",  reg_w, 32'h0000);
        check("inc2_cout_w", cout_w, 1);
        check("inc2_ovf_w",  ovf_w, 1);
        check("inc2_reg_s",  reg_s, 32'hFFFF);
        check("inc2_cout_s", cout_s, 1);
        step();
        check("inc3_reg_w",  reg_w, 32'h0001);
        check("inc3_cout_w", cout_w, 0);
        check("inc3_ovf_w",  ovf_w, 1);

        // saturate-mode decrement across zero
        ctl(0, 1, 0, 0, 0, 0); in_reg = 16'h0001;
        step();
        check("ld_keeps_ovf_w", ovf_w, 1);
        ctl(0, 0, 0, 1, 0, 0);
        step();
        check("dec1_reg_s",  reg_s, 0);
        check("dec1_cout_s", cout_s, 0);
        step();
        check("dec2_reg_s",  reg_s, 0);
        check("dec2_cout_s", cout_s, 1);
        check("dec2_ovf_s",  ovf_s, 1);
        check("dec2_reg_w",  reg_w, 32'hFFFF);
        check("dec2_cout_w", cout_w, 1);
        step();
        check("dec3_reg_s",  reg_s, 0);
        check("dec3_cout_s", cout_s, 1);
        check("dec3_reg_w",  reg_w, 32'hFFFE);
        check("dec3_cout_w", cout_w, 0);
        ctl(0, 0, 0, 0, 0, 0);
        step();
        check("idle_cout_s", cout_s, 0);
        check("idle_reg_s",  reg_s, 0);
        ctl(0, 1, 0, 0, 0, 0); in_reg = 16'h1234;
        step();
        check("ld_reg_s", reg_s, 32'h1234);
        check("ld_ovf_s", ovf_s, 1);
        ctl(1, 0, 0, 0, 0, 0);
        step();
        check("clr_ovf_s", ovf_s, 0);
        check("clr_ovf_w", ovf_w, 0);

        // priority
        ctl(0, 1, 1, 0, 0, 0); in_reg = 16'h00AA;
        step();
        check("pri_ld_inr", reg_w, 32'h00AA);
        ctl(0, 0, 1, 1, 0, 0);
        step();
        check("pri_inr_dcr_reg",  reg_w, 32'h00AA);
        check("pri_inr_dcr_cout", cout_w, 0);
        ctl(1, 1, 0, 0, 0, 0); in_reg = 16'h5555;
        step();
        check("pri_clr_ld", reg_w, 0);

        // shifts
        ctl(0, 1, 0, 0, 0, 0); in_reg = 16'h8001;
        step();
        ctl(0, 0, 0, 0, 1, 1); sin = 1'b0;
        step();
        check("shl_reg",  reg_w, 32'h0002);
        check("shl_cout", cout_w, 1);
        ctl(0, 0, 0, 0, 0, 1); sin = 1'b1;
        step();
        check("shr_reg",  reg_w, 32'h8001);
        check("shr_cout", cout_w, 0);
        check("shr_ovf",  ovf_w, 0);

        // reset overrides a wrapping increment
        ctl(0, 1, 0, 0, 0, 0); in_reg = 16'hFFFF;
        step();
        ctl(0, 0, 1, 0, 0, 0); rstn = 1'b0;
        step();
        check("rst_inc_reg",  reg_w, 32'h0100);
        check("rst_inc_cout", cout_w, 0);
        check("rst_inc_ovf",  ovf_w, 0);
        check("rst_inc_z",    z_w, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
